// File: rtl/croc_pkg.sv
// rtl/croc_pkg.sv - shared SoC types and watchdog register map
// Purpose: OBI subordinate request/response types plus the watchdog register
//          offsets, default kick key and FSM state encoding.
// Ports:   none (package).
package croc_pkg;

  localparam int unsigned SbrObiIdWidth = 2;

  typedef struct packed {
    logic                     req;
    logic [31:0]              addr;
    logic                     we;
    logic [3:0]               be;
    logic [31:0]              wdata;
    logic [SbrObiIdWidth-1:0] aid;
  } sbr_obi_req_t;

  typedef struct packed {
    logic                     gnt;
    logic                     rvalid;
    logic [31:0]              rdata;
    logic                     err;
    logic [SbrObiIdWidth-1:0] rid;
  } sbr_obi_rsp_t;

  // Byte offsets; the block decodes addr[4:2].
  localparam logic [4:0] wdt_ctrl_offset   = 5'h00;
  localparam logic [4:0] wdt_load_offset   = 5'h04;
  localparam logic [4:0] wdt_kick_offset   = 5'h08;
  localparam logic [4:0] wdt_count_offset  = 5'h0C;
  localparam logic [4:0] wdt_status_offset = 5'h10;

  localparam logic [31:0] wdt_kick_key = 32'h5A5A_5A5A;

  typedef enum logic [1:0] {
    wdt_idle = 2'd0,
    wdt_run  = 2'd1,
    wdt_bark = 2'd2,
    wdt_bite = 2'd3
  } wdt_state_e;

endpackage

// File: rtl/obi_watchdog.sv
// rtl/obi_watchdog.sv - two-stage (bark/bite) watchdog on an OBI subordinate port
// Purpose: countdown timer that raises irq_o (bark) on expiry and, if not
//          kicked within the grace window, pulses rst_o (bite).
// Ports:
//   clk_i      in   system clock
//   rst_ni     in   asynchronous active-low reset (pin reset, not watchdog-gated)
//   obi_req_i  in   OBI subordinate request
//   obi_rsp_o  out  OBI subordinate response (gnt always 1, rvalid one cycle later)
//   irq_o      out  bark interrupt level, equals STATUS.BARK
//   rst_o      out  active-high system reset request, driven from a flop
module obi_watchdog
  import croc_pkg::*;
#(
  parameter int unsigned         CntWidth       = 32,
  parameter logic [CntWidth-1:0] DefaultLoad    = CntWidth'(1_000_000),
  parameter int unsigned         GraceCycles    = 1024,
  parameter int unsigned         RstPulseCycles = 16,
  parameter logic [31:0]         KickKey        = wdt_kick_key
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  sbr_obi_req_t obi_req_i,
  output sbr_obi_rsp_t obi_rsp_o,
  output logic         irq_o,
  output logic         rst_o
);

  localparam int unsigned GraceW = (GraceCycles > 1) ? $clog2(GraceCycles) : 1;
  localparam int unsigned PulseW = (RstPulseCycles > 1) ? $clog2(RstPulseCycles) : 1;
  localparam logic [GraceW-1:0] GraceInit = GraceW'(GraceCycles - 1);
  localparam logic [PulseW-1:0] PulseInit = PulseW'(RstPulseCycles - 1);

  wdt_state_e                state_q, state_d;
  logic [CntWidth-1:0]       count_q, count_d, load_q;
  logic [GraceW-1:0]         grace_q, grace_d;
  logic [PulseW-1:0]         pulse_q, pulse_d;
  logic                      ctrl_en_q, ctrl_lock_q, bark_q, cause_q, rst_q;
  logic                      rvalid_q, err_q;
  logic [31:0]               rdata_q, read_data;
  logic [SbrObiIdWidth-1:0]  rid_q;

  logic       acc, wr;
  logic [2:0] reg_idx;
  logic       sel_ctrl, sel_load, sel_kick, sel_count, sel_status, sel_bad;
  logic       lock_err, ctrl_we, load_we, kick_good, kick_bad;
  logic       bark_clr, cause_clr, en_next, bark_set, bite_done;
  logic       unused_bits;

  assign acc        = obi_req_i.req;
  assign wr         = acc & obi_req_i.we;
  assign reg_idx    = obi_req_i.addr[4:2];
  assign sel_ctrl   = (reg_idx == wdt_ctrl_offset[4:2]);
  assign sel_load   = (reg_idx == wdt_load_offset[4:2]);
  assign sel_kick   = (reg_idx == wdt_kick_offset[4:2]);
  assign sel_count  = (reg_idx == wdt_count_offset[4:2]);
  assign sel_status = (reg_idx == wdt_status_offset[4:2]);
  assign sel_bad    = ~(sel_ctrl | sel_load | sel_kick | sel_count | sel_status);

  // LOCK freezes CTRL and LOAD; such writes are dropped and flagged.
  assign lock_err  = wr & ctrl_lock_q & (sel_ctrl | sel_load);
  assign ctrl_we   = wr & sel_ctrl & ~ctrl_lock_q;
  assign load_we   = wr & sel_load & ~ctrl_lock_q;
  assign kick_good = wr & sel_kick & (obi_req_i.wdata == KickKey);
  assign kick_bad  = wr & sel_kick & (obi_req_i.wdata != KickKey) & ctrl_en_q;
  assign bark_clr  = wr & sel_status & obi_req_i.wdata[0];
  assign cause_clr = wr & sel_status & obi_req_i.wdata[1];

  // The FSM reacts to the EN value being written this cycle, so enable and
  // disable take effect at the acceptance edge.
  assign en_next = ctrl_we ? obi_req_i.wdata[0] : ctrl_en_q;

  assign unused_bits = ^{obi_req_i.be, obi_req_i.addr[31:5], obi_req_i.addr[1:0]};

  // Priority in RUN/BARK: disable, bad kick, good kick, then expiry.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    grace_d   = grace_q;
    pulse_d   = pulse_q;
    bark_set  = 1'b0;
    bite_done = 1'b0;
    unique case (state_q)
      wdt_idle: begin
        if (en_next) begin
          state_d = wdt_run;
          count_d = load_q;
        end else if (kick_good) begin
          count_d = load_q;
        end
      end
      wdt_run, wdt_bark: begin
        if (!en_next) begin
          state_d = wdt_idle;
        end else if (kick_bad) begin
          state_d = wdt_bite;
          pulse_d = PulseInit;
        end else if (kick_good) begin
          state_d = wdt_run;
          count_d = load_q;
        end else if (state_q == wdt_run) begin
          if (count_q == '0) begin
            state_d  = wdt_bark;
            grace_d  = GraceInit;
            bark_set = 1'b1;
          end else begin
            count_d = count_q - CntWidth'(1);
          end
        end else begin
          if (grace_q == '0) begin
            state_d = wdt_bite;
            pulse_d = PulseInit;
          end else begin
            grace_d = grace_q - GraceW'(1);
          end
        end
      end
      wdt_bite: begin
        if (pulse_q == '0) begin
          state_d   = wdt_idle;
          bite_done = 1'b1;
        end else begin
          pulse_d = pulse_q - PulseW'(1);
        end
      end
      default: state_d = wdt_idle;
    endcase
  end

  always_comb begin
    read_data = '0;
    if (sel_ctrl)   read_data = {30'd0, ctrl_lock_q, ctrl_en_q};
    if (sel_load)   read_data = 32'(load_q);
    if (sel_count)  read_data = 32'(count_q);
    if (sel_status) read_data = {30'd0, cause_q, bark_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= wdt_idle;
      count_q     <= '0;
      grace_q     <= '0;
      pulse_q     <= '0;
      load_q      <= DefaultLoad;
      ctrl_en_q   <= 1'b0;
      ctrl_lock_q <= 1'b0;
      bark_q      <= 1'b0;
      cause_q     <= 1'b0;
      rst_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      rid_q       <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      grace_q <= grace_d;
      pulse_q <= pulse_d;
      rst_q   <= (state_d == wdt_bite);
      if (bite_done)    ctrl_en_q <= 1'b0;
      else if (ctrl_we) ctrl_en_q <= obi_req_i.wdata[0];
      if (ctrl_we && obi_req_i.wdata[1]) ctrl_lock_q <= 1'b1;
      if (load_we) load_q <= obi_req_i.wdata[CntWidth-1:0];
      // Setting wins over a same-cycle write-1-to-clear.
      if (bark_set)      bark_q <= 1'b1;
      else if (bark_clr) bark_q <= 1'b0;
      if (bite_done)      cause_q <= 1'b1;
      else if (cause_clr) cause_q <= 1'b0;
      rvalid_q <= acc;
      if (acc) rid_q <= obi_req_i.aid;
      err_q   <= acc & (sel_bad | lock_err);
      rdata_q <= (acc && !obi_req_i.we) ? read_data : '0;
    end
  end

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = 1'b1;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.err    = err_q;
    obi_rsp_o.rid    = rid_q;
  end

  assign irq_o = bark_q;
  assign rst_o = rst_q;

endmodule
